// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    BAUD_9600   = 2'd0,
    BAUD_19200  = 2'd1,
    BAUD_57600  = 2'd2,
    BAUD_115200 = 2'd3
  } baudrate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Clock cycles spanned by one serial bit at the selected rate.
  function automatic int cycles_per_bit(input int clock_frequency, input baudrate_t baudrate);
    case (baudrate)
      BAUD_9600:   return clock_frequency / 9600;
      BAUD_19200:  return clock_frequency / 19200;
      BAUD_57600:  return clock_frequency / 57600;
      default:     return clock_frequency / 115200;
    endcase
  endfunction

endpackage

// File: rtl/uart_receiver_fifo.sv
// First-word fall-through receive FIFO with fill-level flag and overrun pulse.
module uart_receiver_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       read_enable,
  input  logic [5:0] buffer_full_threshold,
  output logic [7:0] data_out,
  output logic       buffer_empty,
  output logic       buffer_full,
  output logic       overrun_error
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop;
  logic          at_capacity;
  logic          do_push;

  // A pop in the same cycle frees a slot, so a push at capacity still lands.
  assign pop          = read_enable && (count != '0);
  assign at_capacity  = (count == (AW+1)'(DEPTH));
  assign do_push      = push && (!at_capacity || pop);
  assign buffer_empty = (count == '0);
  assign buffer_full  = (count >= (AW+1)'(buffer_full_threshold));
  assign data_out     = buffer_empty ? 8'h00 : mem[rd_ptr];

  // Pointer, occupancy and overrun bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overrun_error <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overrun_error <= push && at_capacity && !pop;
    end
  end

  // Storage array; left unreset since the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (reset && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: input synchronizer, bit-recovery FSM and receive FIFO.
//
//   state | meaning
//   IDLE  | line idle, waiting for a falling edge on rx_sync
//   START | counting half a bit to re-check the start bit mid-bit
//   DATA  | sampling the 8 data bits, LSB first, once per bit time
//   STOP  | sampling the stop bit; high pushes the byte, low flags a frame error
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BUFFER_DEPTH    = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in,
  input  logic [1:0] baudrate_select,
  input  logic [5:0] buffer_full_threshold,
  input  logic       read_enable,
  output logic [7:0] data_out,
  output logic       buffer_empty,
  output logic       buffer_full,
  output logic       frame_error,
  output logic       overrun_error
);

  localparam int CW = $clog2(CLOCK_FREQUENCY / 9600 + 1);

  logic          rx_meta, rx_sync, rx_prev;
  rx_state_t     state, state_next;
  baudrate_t     baud_q, baud_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift, shift_next;
  logic          push_req, push_req_next;
  logic          frame_err_next;
  logic [CW-1:0] cpb_select, cpb_frame, half_load;

  // Half-bit timing uses the live select because it is latched on that same edge.
  assign cpb_select = CW'(cycles_per_bit(CLOCK_FREQUENCY, baudrate_t'(baudrate_select)));
  assign cpb_frame  = CW'(cycles_per_bit(CLOCK_FREQUENCY, baud_q));
  assign half_load  = (cpb_select >> 1) - CW'(1);

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= data_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // FSM state, bit timer, shift register and registered push/error strobes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      baud_q      <= BAUD_9600;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      push_req    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      baud_q      <= baud_next;
      cnt         <= cnt_next;
      bit_idx     <= bit_idx_next;
      shift       <= shift_next;
      push_req    <= push_req_next;
      frame_error <= frame_err_next;
    end
  end

  // Next-state logic; the bit timer counts down and acts on terminal count zero.
  always_comb begin
    state_next     = state;
    baud_next      = baud_q;
    cnt_next       = cnt;
    bit_idx_next   = bit_idx;
    shift_next     = shift;
    push_req_next  = 1'b0;
    frame_err_next = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_next = START;
          baud_next  = baudrate_t'(baudrate_select);
          cnt_next   = half_load;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rx_sync) begin
            state_next   = DATA;
            bit_idx_next = '0;
            cnt_next     = cpb_frame - CW'(1);
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_next = {rx_sync, shift[7:1]};
          cnt_next   = cpb_frame - CW'(1);
          if (bit_idx == 3'(DATA_BITS - 1)) state_next = STOP;
          else bit_idx_next = bit_idx + 3'd1;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      STOP: begin
        if (cnt == '0) begin
          state_next = IDLE;
          if (rx_sync) push_req_next  = 1'b1;
          else         frame_err_next = 1'b1;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  uart_receiver_fifo #(.DEPTH(BUFFER_DEPTH)) u_fifo (
    .clock                 (clock),
    .reset                 (reset),
    .push                  (push_req),
    .push_data             (shift),
    .read_enable           (read_enable),
    .buffer_full_threshold (buffer_full_threshold),
    .data_out              (data_out),
    .buffer_empty          (buffer_empty),
    .buffer_full           (buffer_full),
    .overrun_error         (overrun_error)
  );

endmodule

// File: tb/tb_uart_receiver.sv
// Directed plus randomized bench for uart_receiver against a queue-based model.
module tb_uart_receiver;

  localparam int CLK_HZ = 1_152_000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b1;
  logic [1:0] baudrate_select = 2'd0;
  logic [5:0] buffer_full_threshold = 6'd0;
  logic       read_enable = 1'b0;
  logic [7:0] data_out;
  logic       buffer_empty, buffer_full, frame_error, overrun_error;

  uart_receiver #(.CLOCK_FREQUENCY(CLK_HZ), .BUFFER_DEPTH(64)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .data_in               (data_in),
    .baudrate_select       (baudrate_select),
    .buffer_full_threshold (buffer_full_threshold),
    .read_enable           (read_enable),
    .data_out              (data_out),
    .buffer_empty          (buffer_empty),
    .buffer_full           (buffer_full),
    .frame_error           (frame_error),
    .overrun_error         (overrun_error)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int fe_seen = 0;
  int ov_seen = 0;
  logic [7:0] exp_q[$];

  logic       obs_empty_pre, obs_empty_post, obs_fe_pre, obs_fe_post, obs_fe_after, obs_ov_post;
  logic [7:0] obs_head_pre;

  always @(negedge clock) begin
    if (frame_error)   fe_seen++;
    if (overrun_error) ov_seen++;
  end

  function automatic int bit_cycles(input int sel);
    int baud;
    baud = (sel == 0) ? 9600 : (sel == 1) ? 19200 : (sel == 2) ? 57600 : 115200;
    return CLK_HZ / baud;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one full frame; captures outputs around the expected push point.
  // Push lands 4 + half + 9 bit times after the start bit is driven
  // (2 sync flops, edge detect, half bit, 9 bit times, registered push).
  task automatic send_frame(input logic [7:0] b, input int sel, input logic stop_bit,
                            input logic pop_at_push, input int sel_mid);
    int cpb, lat;
    logic [9:0] bits;
    cpb  = bit_cycles(sel);
    lat  = 4 + cpb / 2 + 9 * cpb;
    bits = {stop_bit, b, 1'b0};
    baudrate_select = 2'(sel);
    for (int cyc = 0; cyc < 10 * cpb + 2; cyc++) begin
      @(negedge clock);
      if (cyc == lat - 2) obs_fe_pre = frame_error;
      if (cyc == lat - 1) begin
        obs_empty_pre = buffer_empty;
        obs_head_pre  = data_out;
        obs_fe_post   = frame_error;
        if (pop_at_push) read_enable = 1'b1;
      end
      if (cyc == lat) begin
        obs_empty_post = buffer_empty;
        obs_ov_post    = overrun_error;
        obs_fe_after   = frame_error;
        read_enable    = 1'b0;
      end
      if (cyc == 5 * cpb) baudrate_select = 2'(sel_mid);
      data_in = (cyc < 10 * cpb) ? bits[cyc / cpb] : 1'b1;
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b, input logic stop_bit,
                             input logic pop_at_push);
    int   sz;
    logic exp_ov;
    sz     = exp_q.size();
    exp_ov = stop_bit && (sz == 64) && !pop_at_push;
    chk({tag, " frame_error before"}, obs_fe_pre, 0);
    chk({tag, " frame_error"}, obs_fe_post, !stop_bit);
    chk({tag, " frame_error after"}, obs_fe_after, 0);
    chk({tag, " overrun"}, obs_ov_post, exp_ov);
    chk({tag, " empty before push"}, obs_empty_pre, sz == 0);
    if (pop_at_push && sz > 0) begin
      chk({tag, " head at pop"}, obs_head_pre, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (stop_bit && !exp_ov) exp_q.push_back(b);
    chk({tag, " empty after push"}, obs_empty_post, exp_q.size() == 0);
    chk({tag, " full flag"}, buffer_full, exp_q.size() >= int'(buffer_full_threshold));
    if (exp_q.size() > 0) chk({tag, " head"}, data_out, exp_q[0]);
  endtask

  task automatic pop_one(input string tag);
    @(negedge clock);
    chk({tag, " empty"}, buffer_empty, exp_q.size() == 0);
    if (exp_q.size() > 0) chk({tag, " data"}, data_out, exp_q[0]);
    read_enable = 1'b1;
    @(negedge clock);
    read_enable = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  initial begin
    int base_fe, base_ov, sel;
    logic [7:0] b;

    // Reset with idle line.
    repeat (5) @(negedge clock);
    chk("reset empty", buffer_empty, 1);
    chk("reset data_out", data_out, 0);
    chk("reset frame_error", frame_error, 0);
    chk("reset overrun", overrun_error, 0);
    chk("reset full thr0", buffer_full, 1);
    reset = 1'b1;
    buffer_full_threshold = 6'd63;
    #1;
    chk("full thr63", buffer_full, 0);

    // Basic frames at the fastest and slowest rates.
    send_frame(8'hA5, 3, 1'b1, 1'b0, 3);
    check_frame("a5", 8'hA5, 1'b1, 1'b0);
    chk("a5 value", data_out, 8'hA5);
    pop_one("a5 pop");
    @(negedge clock);
    chk("a5 empty after pop", buffer_empty, 1);
    send_frame(8'h3C, 0, 1'b1, 1'b0, 0);
    check_frame("3c", 8'h3C, 1'b1, 1'b0);
    pop_one("3c pop");

    // Read on empty is ignored.
    pop_one("empty pop");
    @(negedge clock);
    chk("empty pop empty", buffer_empty, 1);
    chk("empty pop data", data_out, 0);

    // Start glitch shorter than half a bit.
    base_fe = fe_seen;
    base_ov = ov_seen;
    baudrate_select = 2'd3;
    @(negedge clock);
    data_in = 1'b0;
    repeat (3) @(negedge clock);
    data_in = 1'b1;
    repeat (100) @(negedge clock);
    chk("glitch empty", buffer_empty, 1);
    chk("glitch no frame_error", fe_seen - base_fe, 0);
    chk("glitch no overrun", ov_seen - base_ov, 0);
    send_frame(8'h55, 3, 1'b1, 1'b0, 3);
    check_frame("55", 8'h55, 1'b1, 1'b0);
    pop_one("55 pop");

    // Stop bit low.
    base_fe = fe_seen;
    send_frame(8'h81, 3, 1'b0, 1'b0, 3);
    check_frame("81 bad stop", 8'h81, 1'b0, 1'b0);
    @(negedge clock);
    chk("81 single pulse", fe_seen - base_fe, 1);
    chk("81 fifo unchanged", buffer_empty, 1);

    // Threshold, fill to capacity, overrun.
    buffer_full_threshold = 6'd4;
    for (int i = 0; i < 64; i++) begin
      send_frame(8'(i), 3, 1'b1, 1'b0, 3);
      check_frame("fill", 8'(i), 1'b1, 1'b0);
    end
    base_ov = ov_seen;
    send_frame(8'hFF, 3, 1'b1, 1'b0, 3);
    check_frame("overrun", 8'hFF, 1'b1, 1'b0);
    @(negedge clock);
    chk("overrun single pulse", ov_seen - base_ov, 1);
    for (int i = 0; i < 64; i++) begin
      chk("drain order", data_out, 8'(i));
      pop_one("drain");
    end
    @(negedge clock);
    chk("drained empty", buffer_empty, 1);

    // Random refill, then a pop coinciding with a push at capacity.
    for (int i = 0; i < 64; i++) begin
      b   = 8'($urandom);
      sel = int'($urandom_range(2, 3));
      send_frame(b, sel, 1'b1, 1'b0, sel);
      check_frame("refill", b, 1'b1, 1'b0);
    end
    base_ov = ov_seen;
    b = 8'($urandom);
    send_frame(b, 3, 1'b1, 1'b1, 3);
    check_frame("pop at full", b, 1'b1, 1'b1);
    chk("pop at full no overrun", ov_seen - base_ov, 0);
    for (int i = 0; i < 64; i++) pop_one("drain2");

    // Select change mid-frame has no effect until the next frame.
    b = 8'($urandom);
    send_frame(b, 3, 1'b1, 1'b0, 0);
    check_frame("mid change", b, 1'b1, 1'b0);
    b = 8'($urandom);
    send_frame(b, 0, 1'b1, 1'b0, 0);
    check_frame("after change", b, 1'b1, 1'b0);
    pop_one("mid pop1");
    pop_one("mid pop2");

    // Random rates and bytes.
    for (int k = 0; k < 4; k++) begin
      b   = 8'($urandom);
      sel = int'($urandom_range(0, 3));
      send_frame(b, sel, 1'b1, 1'b0, sel);
      check_frame("random", b, 1'b1, 1'b0);
      pop_one("random pop");
    end

    // Reset in the middle of a frame.
    base_fe = fe_seen;
    b = 8'h96;
    baudrate_select = 2'd3;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clock);
      data_in = (cyc < 10) ? 1'b0 : b[(cyc - 10) / 10];
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    data_in = 1'b1;
    reset   = 1'b1;
    exp_q.delete();
    repeat (150) @(negedge clock);
    chk("midreset empty", buffer_empty, 1);
    chk("midreset data_out", data_out, 0);
    chk("midreset no frame_error", fe_seen - base_fe, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage, directly downstream of uart_transmitter; its data_in is driven by the transmitter's data_out line.
- Recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) at one of four baud rates.
- Stores recovered bytes in a 64-entry receive FIFO with a programmable fullness flag, mirroring the transmitter's buffer.

Parameters:
- CLOCK_FREQUENCY, 50_000_000, system clock frequency in Hz; sets cycles-per-bit.
- BUFFER_DEPTH, 64, receive FIFO depth in bytes; must be a power of two, at least 64.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- data_in  input  1  asynchronous serial RX line; idle high.
- baudrate_select  input  2  0=9600, 1=19200, 2=57600, 3=115200 baud.
- buffer_full_threshold  input  6  fill level at or above which buffer_full asserts.
- read_enable  input  1  pops the FIFO head when buffer_empty=0.
- data_out  output  8  FIFO head byte (first-word fall-through); valid while buffer_empty=0.
- buffer_empty  output  1  FIFO holds 0 bytes.
- buffer_full  output  1  FIFO count >= buffer_full_threshold.
- frame_error  output  1  one-cycle pulse: stop bit sampled low, byte discarded.
- overrun_error  output  1  one-cycle pulse: valid byte arrived with FIFO at BUFFER_DEPTH, byte dropped.

Behaviour:
- Reset (reset=0 at a rising edge):
  - FSM goes to IDLE, counters clear, FIFO empties.
  - Synchronizer flops are set to 1.
  - Outputs: data_out=0, buffer_empty=1, buffer_full=(threshold==0), frame_error=0, overrun_error=0.
  - Reset mid-frame abandons the frame; nothing is pushed.
- data_in passes through a 2-flop synchronizer (rx_sync, set to 1 on reset); all decisions use rx_sync.
- Cycles per bit: CPB = CLOCK_FREQUENCY / baud (integer division); HALF = CPB / 2.
- baudrate_select is latched when start is detected and held for the whole frame; changes mid-frame have no effect on that frame.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_sync falling edge (previous 1, current 0) -> START; clear counter.
  - START: after HALF cycles, sample rx_sync.
    - 0 -> DATA, bit_index=0.
    - 1 -> false start; return to IDLE, no error flagged.
  - DATA: every CPB cycles, sample rx_sync into shift register bit[bit_index], LSB first. After bit 7 is sampled -> STOP.
  - STOP: after CPB cycles, sample rx_sync.
    - 1 -> push byte.
    - 0 -> frame_error pulse on the next cycle, byte discarded.
    - Either case -> IDLE. A new start edge is accepted from the cycle after the STOP sample.
- Push timing: the FIFO write occurs on the clock edge following the STOP sample; buffer_empty/count update in the same cycle as the write.
- FIFO:
  - Read/write pointers are log2(BUFFER_DEPTH) bits and wrap modulo depth.
  - count is log2(BUFFER_DEPTH)+1 bits.
  - read_enable with buffer_empty=1 is ignored: no pointer change, no error.
  - Simultaneous push and pop: both occur, count unchanged. When full, a simultaneous pop makes room, so the push succeeds and there is no overrun.
  - Push with count==BUFFER_DEPTH and no pop: byte dropped, overrun_error pulses 1 cycle, FIFO contents unchanged.
  - buffer_full is combinational on count vs buffer_full_threshold. A threshold change takes effect immediately.
- Error pulses are exactly 1 cycle, and frame_error and overrun_error are mutually exclusive per frame.

Decomposition:
- Package uart_pkg:
  - baudrate_t enum (BAUD_9600, BAUD_19200, BAUD_57600, BAUD_115200).
  - DATA_BITS=8.
  - Function cycles_per_bit(clock_frequency, baudrate_t).
  - rx_state_t enum (IDLE, START, DATA, STOP).
  - Shared with uart_transmitter.
- Sub-module uart_receiver_fifo: synchronous FWFT FIFO with push/pop, count, empty, threshold flag and overrun pulse. The top level holds the synchronizer, FSM and baud counter.

Test Plan:
All scenarios use CLOCK_FREQUENCY=1_152_000, so CPB = 120 / 60 / 20 / 10 for selects 0..3.
- Reset for 5 cycles with data_in=1 -> buffer_empty=1, data_out=0, both error flags 0. Reset asserted mid-frame (after bit 3) -> nothing pushed, FIFO stays empty.
- baudrate_select=3, send 0xA5 (LSB first) -> buffer_empty=0 one cycle after the STOP sample, data_out=0xA5. read_enable for 1 cycle -> buffer_empty=1. Repeat at select 0 with 0x3C -> 0x3C received.
- Start glitch: data_in low for 3 cycles at select=3 (less than HALF=5) -> false start, FSM returns to IDLE, no push, no error. A following valid 0x55 frame is received correctly.
- Send 0x81 with stop bit driven 0 -> frame_error high for exactly 1 cycle, FIFO unchanged.
- Threshold and overrun:
  - Threshold=4: push 4 bytes 0x00..0x03 -> buffer_full=1 after the 4th push.
  - Fill to 64 bytes, send 0xFF -> overrun_error 1 cycle; 64 pops return 0x00..0x3F in order.
  - Pop coincident with a push at full -> no overrun.
- Change baudrate_select 3->0 mid-frame -> frame still decoded at 115200. The next frame decodes at 9600.
